// File: rtl/bank_write_packer_pkg.sv
// Shared definitions for the bank write packer: FSM state encoding and default sizes.
package bank_write_packer_pkg;

   localparam int DEF_DATA_WIDTH      = 16;
   localparam int DEF_LANES           = 4;
   localparam int DEF_BANK_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FILL      = 2'd1,
      ST_WAIT_SWAP = 2'd2
   } bwp_state_e;

endpackage

// File: rtl/bank_write_packer_lane_packer.sv
// Collects accepted stream elements into one bank word, lane 0 first.
// A word closes on the last lane or on in_last; unfilled lanes stay zero.
module lane_packer
   import bank_write_packer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LANES      = DEF_LANES
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_acc,
   input  logic [DATA_WIDTH-1:0]         i_dat,
   input  logic                          i_last,
   output logic                          o_done,
   output logic [DATA_WIDTH*LANES-1:0]   o_wdata
);

   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 1);

   logic [CW-1:0]                r_cnt;
   logic [DATA_WIDTH*LANES-1:0]  r_part;
   logic [DATA_WIDTH*LANES-1:0]  w_next;

   always_comb begin
      w_next = r_part;
      for (int k = 0; k < LANES; k++) begin
         if (r_cnt == CW'(k)) begin
            w_next[k*DATA_WIDTH +: DATA_WIDTH] = i_dat;
         end
      end
   end

   assign o_done = i_acc && ((r_cnt == CNT_LAST) || i_last);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_part  <= '0;
         o_wdata <= '0;
      end else if (i_acc) begin
         if (o_done) begin
            // the partial register restarts at zero so short words come out zero-padded
            o_wdata <= w_next;
            r_part  <= '0;
            r_cnt   <= '0;
         end else begin
            r_part  <= w_next;
            r_cnt   <= r_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/bank_write_packer.sv
// Packs an element stream into bank words and sequences double-buffer bank swaps.
//   state        | meaning
//   ST_IDLE      | waiting for a frame configuration (words per bank)
//   ST_FILL      | accepting elements, writing packed words
//   ST_WAIT_SWAP | bank full or frame ended, waiting for reader to free the other bank
module bank_write_packer
   import bank_write_packer_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int LANES           = DEF_LANES,
   parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_cfg_vld,
   output logic                          o_cfg_rdy,
   input  logic [BANK_ADDR_WIDTH:0]      i_cfg_words,
   input  logic                          i_in_vld,
   output logic                          o_in_rdy,
   input  logic [DATA_WIDTH-1:0]         i_in_dat,
   input  logic                          i_in_last,
   output logic                          o_wen,
   output logic [BANK_ADDR_WIDTH-1:0]    o_wadr,
   output logic [DATA_WIDTH*LANES-1:0]   o_wdata,
   output logic                          o_switch_banks,
   input  logic                          i_bank_free,
   output logic                          o_busy
);

   localparam int BAW = BANK_ADDR_WIDTH;
   localparam logic [BAW:0]   W_MAX   = {1'b1, {BAW{1'b0}}};
   localparam logic [BAW:0]   W_ONE   = (BAW+1)'(1);
   localparam logic [BAW-1:0] ADR_ONE = BAW'(1);

   bwp_state_e      r_state;
   logic [BAW:0]    r_words;
   logic [BAW-1:0]  r_next_adr;
   logic [BAW-1:0]  r_wadr;
   logic            r_wen;
   logic            r_switch;
   logic            r_ended;
   logic            w_acc;
   logic            w_done;
   logic            w_full;

   assign o_cfg_rdy      = (r_state == ST_IDLE);
   assign o_in_rdy       = (r_state == ST_FILL);
   assign o_busy         = (r_state != ST_IDLE);
   assign o_wen          = r_wen;
   assign o_wadr         = r_wadr;
   assign o_switch_banks = r_switch;

   assign w_acc  = i_in_vld && (r_state == ST_FILL);
   assign w_full = ({1'b0, r_next_adr} == (r_words - W_ONE));

   lane_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
   ) u_lane_packer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_acc   (w_acc),
      .i_dat   (i_in_dat),
      .i_last  (i_in_last),
      .o_done  (w_done),
      .o_wdata (o_wdata)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_words    <= '0;
         r_next_adr <= '0;
         r_wadr     <= '0;
         r_wen      <= 1'b0;
         r_switch   <= 1'b0;
         r_ended    <= 1'b0;
      end else begin
         r_wen    <= 1'b0;
         r_switch <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_cfg_vld) begin
                  // zero and anything past the bank size both mean a full bank
                  r_words    <= ((i_cfg_words == '0) || i_cfg_words[BAW]) ? W_MAX : i_cfg_words;
                  r_next_adr <= '0;
                  r_ended    <= 1'b0;
                  r_state    <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (w_done) begin
                  r_wen      <= 1'b1;
                  r_wadr     <= r_next_adr;
                  r_next_adr <= r_next_adr + ADR_ONE;
                  if (w_full || i_in_last) begin
                     r_ended <= i_in_last;
                     r_state <= ST_WAIT_SWAP;
                  end
               end
            end
            ST_WAIT_SWAP: begin
               if (i_bank_free) begin
                  r_switch   <= 1'b1;
                  r_wadr     <= '0;
                  r_next_adr <= '0;
                  r_state    <= r_ended ? ST_IDLE : ST_FILL;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bank_write_packer.sv
// Randomized scoreboard bench for bank_write_packer against a queue-based frame model.
module tb_bank_write_packer;
   import bank_write_packer_pkg::*;

   localparam int DW = 16;
   localparam int LN = 4;
   localparam int AW = 8;

   typedef struct {
      logic [AW-1:0]    adr;
      logic [DW*LN-1:0] dat;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_vld, cfg_rdy;
   logic [AW:0]       cfg_words;
   logic              in_vld, in_rdy, in_last;
   logic [DW-1:0]     in_dat;
   logic              wen, sw, bank_free, busy;
   logic [AW-1:0]     wadr;
   logic [DW*LN-1:0]  wdata;

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  n_wen = 0, n_sw = 0, last_wen_cyc = 0, last_sw_cyc = 0;
   bit  bf_rand = 1'b0;

   wr_t           exp_wr[$];
   bit            exp_sw[$];
   wr_t           mon_wr;
   bit            mon_end;
   logic [DW-1:0] m_lanes[$];
   int            m_adr = 0;
   int            m_words = 1;

   bank_write_packer #(
      .DATA_WIDTH      (DW),
      .LANES           (LN),
      .BANK_ADDR_WIDTH (AW)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_cfg_vld      (cfg_vld),
      .o_cfg_rdy      (cfg_rdy),
      .i_cfg_words    (cfg_words),
      .i_in_vld       (in_vld),
      .o_in_rdy       (in_rdy),
      .i_in_dat       (in_dat),
      .i_in_last      (in_last),
      .o_wen          (wen),
      .o_wadr         (wadr),
      .o_wdata        (wdata),
      .o_switch_banks (sw),
      .i_bank_free    (bank_free),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bf_rand) bank_free = ($urandom_range(0, 3) != 0);

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   function automatic void fail(string nm, logic [63:0] val);
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h, nothing expected", nm, val);
   endfunction

   // reference model: frame rules expressed on element lists
   task automatic model_cfg(input int w);
      m_words = (w == 0) ? (1 << AW) : w;
      m_adr   = 0;
      m_lanes.delete();
   endtask

   task automatic model_acc(input logic [DW-1:0] d, input bit l);
      wr_t e;
      m_lanes.push_back(d);
      if (m_lanes.size() == LN || l) begin
         e.adr = AW'(m_adr);
         e.dat = '0;
         foreach (m_lanes[k]) e.dat = e.dat + ((DW*LN)'(m_lanes[k]) << (DW * k));
         exp_wr.push_back(e);
         m_lanes.delete();
         m_adr++;
         if (m_adr == m_words || l) begin
            exp_sw.push_back(l);
            m_adr = 0;
         end
      end
   endtask

   task automatic model_flush();
      exp_wr.delete();
      exp_sw.delete();
      m_lanes.delete();
      m_adr = 0;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (wen) begin
            n_wen++;
            last_wen_cyc = cyc;
            chk("sw_during_wen", sw, 0);
            if (exp_wr.size() == 0) fail("unexpected_wen", wadr);
            else begin
               mon_wr = exp_wr.pop_front();
               chk("wadr", wadr, mon_wr.adr);
               chk("wdata", wdata, mon_wr.dat);
            end
         end
         if (sw) begin
            n_sw++;
            last_sw_cyc = cyc;
            if (exp_sw.size() == 0) fail("unexpected_switch", wadr);
            else begin
               mon_end = exp_sw.pop_front();
               chk("switch_cfg_rdy", cfg_rdy, mon_end);
               chk("switch_in_rdy", in_rdy, !mon_end);
               chk("switch_wadr", wadr, 0);
            end
         end
      end
   end

   // drivers: all called and returning at a negedge
   task automatic configure(input int w);
      int t = 0;
      cfg_words = (AW+1)'(w);
      cfg_vld   = 1'b1;
      while (!cfg_rdy && t < 3000) begin @(negedge clk); t++; end
      if (!cfg_rdy) fail("cfg_rdy_timeout", t);
      model_cfg(w);
      @(negedge clk);
      cfg_vld = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d, input bit l);
      int t = 0;
      in_vld  = 1'b1;
      in_dat  = d;
      in_last = l;
      while (!in_rdy && t < 3000) begin @(negedge clk); t++; end
      if (!in_rdy) fail("in_rdy_timeout", t);
      else model_acc(d, l);
      @(negedge clk);
      in_vld  = 1'b0;
      in_last = 1'b0;
      in_dat  = DW'($urandom);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         in_vld = 1'b0;
         in_dat = DW'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_wr.size() != 0 || exp_sw.size() != 0) && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) fail("drain_timeout", exp_wr.size() + exp_sw.size());
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cfg_rdy"}, cfg_rdy, 1);
      chk({tag, "_in_rdy"}, in_rdy, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_wen"}, wen, 0);
      chk({tag, "_switch"}, sw, 0);
      chk({tag, "_wadr"}, wadr, 0);
      chk({tag, "_wdata"}, wdata, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, bf_cyc, t;
      rst = 1'b1; cfg_vld = 1'b0; cfg_words = '0; in_vld = 1'b0;
      in_dat = '0; in_last = 1'b0; bank_free = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("init");
      rst = 1'b0;
      @(negedge clk);

      // three-word bank, 12 elements back to back, reader always free
      bank_free = 1'b1;
      configure(3);
      chk("fill_in_rdy", in_rdy, 1);
      chk("fill_cfg_rdy", cfg_rdy, 0);
      chk("fill_busy", busy, 1);
      for (int i = 1; i <= 12; i++) send(DW'(i), 1'b0);
      drain();
      chk("swap_latency", last_sw_cyc - last_wen_cyc, 1);
      chk("refill_in_rdy", in_rdy, 1);

      // reset in the middle of a word with traffic active
      for (int i = 1; i <= 6; i++) send(DW'(i), 1'b0);
      in_vld = 1'b1;
      in_dat = 16'h0007;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      model_flush();
      in_vld = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // short frame ending with in_last
      configure(3);
      for (int i = 1; i <= 5; i++) send(DW'(i), 1'b0);
      send(16'h0006, 1'b1);
      drain();
      @(negedge clk);
      chk("frame_end_busy", busy, 0);
      chk("frame_end_cfg_rdy", cfg_rdy, 1);

      // reader holds the other bank for 10 cycles
      configure(1);
      bank_free = 1'b0;
      for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0);
      t = 0;
      while (exp_wr.size() != 0 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) fail("full_wen_timeout", t);
      repeat (10) begin
         @(negedge clk);
         chk("hold_in_rdy", in_rdy, 0);
         chk("hold_wen", wen, 0);
         chk("hold_switch", sw, 0);
      end
      bank_free = 1'b1;
      bf_cyc = cyc;
      drain();
      chk("free_to_switch", last_sw_cyc - bf_cyc, 1);
      send(16'h0005, 1'b1);
      drain();

      // in_vld gaps 1,0,0,1,1,0,1 with a stray cfg_vld while filling
      configure(2);
      n0 = n_wen;
      send(16'h0001, 1'b0);
      cfg_words = 9'd1;
      cfg_vld = 1'b1;
      gap(2);
      cfg_vld = 1'b0;
      send(16'h0002, 1'b0);
      send(16'h0003, 1'b0);
      gap(1);
      chk("gap_no_early_wen", n_wen - n0, 0);
      send(16'h0004, 1'b0);
      chk("gap_wen_timing", wen, 1);
      chk("gap_wdata", wdata, 64'h0004_0003_0002_0001);
      send(16'h0005, 1'b1);
      drain();

      // cfg_words=0 means a full 256-word bank
      configure(0);
      n0 = n_wen;
      for (int i = 0; i < 1024; i++) send(DW'($urandom), 1'b0);
      drain();
      chk("deep_wen_count", n_wen - n0, 256);
      send(16'h1234, 1'b1);
      drain();

      // randomized frames with random gaps and reader stalls
      bf_rand = 1'b1;
      for (int f = 0; f < 25; f++) begin
         int len;
         configure($urandom_range(1, 4));
         len = $urandom_range(1, 30);
         for (int e = 0; e < len; e++) begin
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
            send(DW'($urandom), e == len - 1);
         end
      end
      drain();
      bf_rand = 1'b0;

      chk("end_wr_queue", exp_wr.size(), 0);
      chk("end_sw_queue", exp_sw.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bank_write_packer.md
BANK_WRITE_PACKER -- requirements
Module: bank_write_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one stream element.
REQ-002 SHALL have parameter LANES, default 4, elements packed per bank word (>=1).
REQ-003 SHALL have parameter BANK_ADDR_WIDTH, default 8, double-buffer bank address width.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cfg_vld in 1 / cfg_rdy out 1 / cfg_words in BANK_ADDR_WIDTH+1: words per bank fill.
REQ-007 SHALL have ports in_vld in 1 / in_rdy out 1 / in_dat in DATA_WIDTH / in_last in 1: element stream.
REQ-008 SHALL have ports wen out 1 / wadr out BANK_ADDR_WIDTH / wdata out DATA_WIDTH*LANES: bank write.
REQ-009 SHALL have ports switch_banks out 1 (one-cycle swap pulse) / bank_free in 1 (reader done with other bank).
REQ-010 SHALL have port busy out 1, high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, FILL, WAIT_SWAP.
REQ-012 IDLE: cfg_rdy=1, in_rdy=0; on cfg_vld latch cfg_words (0 means 2^BANK_ADDR_WIDTH), go FILL next cycle.
REQ-013 FILL: in_rdy=1, cfg_rdy=0; element accepted when in_vld&&in_rdy; one element per cycle sustained.
REQ-014 Accepted element k of a word SHALL occupy wdata lane k, bits [k*DATA_WIDTH +: DATA_WIDTH]; lane 0 = first.
REQ-015 Word completes on LANES-th accepted element or on accepted in_last; unfilled lanes SHALL be zero.
REQ-016 wen SHALL pulse exactly one cycle, the cycle after the completing accept, with wadr = current word address.
REQ-017 wadr SHALL start at 0 per bank and increment by 1 after each write.
REQ-018 Write at wadr = cfg_words-1, or write of an in_last word, SHALL move state to WAIT_SWAP in the wen cycle; in_rdy=0 from that cycle.
REQ-019 WAIT_SWAP: when bank_free sampled high, switch_banks SHALL pulse the following cycle, wadr resets to 0.
REQ-020 Switch cycle SHALL be in FILL with in_rdy=1, unless frame ended by in_last, then IDLE with cfg_rdy=1.
REQ-021 bank_free high on entry to WAIT_SWAP SHALL still cost one cycle before switch_banks; low holds WAIT_SWAP indefinitely.
REQ-022 in_vld gaps SHALL not alter packing or lane position; in_dat ignored when not accepted.
REQ-023 wen and switch_banks SHALL never be high in the same cycle.
REQ-024 cfg_vld outside IDLE SHALL be ignored (cfg_rdy low).

Reset
REQ-025 rst high SHALL immediately force IDLE, lane count 0, wadr 0, wdata 0, wen 0, switch_banks 0, in_rdy 0, busy 0, cfg_rdy 1.
REQ-026 Reset mid-word or mid-bank SHALL discard partial data; no wen or switch_banks emitted for it.

Structure
REQ-027 State enum and default parameter constants SHALL live in the shared accelerator package.
REQ-028 One sub-module lane_packer (lane counter, shift/zero-pad register) SHALL hold packing; FSM and address counter stay in bank_write_packer.

Verification (LANES=4, DATA_WIDTH=16, BANK_ADDR_WIDTH=8)
REQ-029 Reset with traffic active -> all outputs at REQ-025 values, cfg_rdy=1 the cycle rst asserts.
REQ-030 cfg_words=3, stream 1..12 back-to-back, bank_free=1 -> wen at wadr 0,1,2 with wdata 0x0004_0003_0002_0001, 0x0008_0007_0006_0005, 0x000C_000B_000A_0009; switch_banks one cycle after WAIT_SWAP entry; back in FILL.
REQ-031 cfg_words=3, elements 1..6 with in_last on 6 -> wadr0 0x0004_0003_0002_0001, wadr1 0x0000_0000_0006_0005, switch_banks, then IDLE with cfg_rdy=1.
REQ-032 Bank full with bank_free=0 for 10 cycles -> in_rdy=0, no wen, no switch for 10 cycles; switch_banks one cycle after bank_free rises.
REQ-033 in_vld toggling 1,0,0,1,1,0,1 over elements 1..4 -> single wen with 0x0004_0003_0002_0001 one cycle after fourth accept.
REQ-034 cfg_words=0, 1024 elements -> 256 writes at wadr 0..255 then WAIT_SWAP.
